// File: rtl/mem_bus_responder_pkg.sv
// Shared constants and types for the data-memory bus responder.
// Holds the peripheral address map and the bus FSM state encoding.
package mem_bus_responder_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;

  localparam logic [7:0] ADDR_LEDR  = 8'h80;
  localparam logic [7:0] ADDR_SW    = 8'h90;
  localparam logic [7:0] ADDR_TCNT  = 8'hA0;
  localparam logic [7:0] ADDR_TSTAT = 8'hB0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RWAIT = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Single-port synchronous RAM with write enable and registered read data.
// The read register only updates when re_i is high, so it holds across wait cycles.
module bus_ram #(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Target side of the processor data-memory bus: 4-phase Req/Ack responder
// decoding RAM, LED register, synchronised switches and a countdown timer.
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAM_DEPTH = 128,
  parameter int RAM_WAIT  = 1,
  parameter int TICK_DIV  = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Req,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic              W,
  input  logic [DATA_W-1:0] DOUT,
  output logic [DATA_W-1:0] DIN,
  output logic              Ack,
  input  logic [9:0]        SW,
  output logic [9:0]        LEDR,
  output logic              TimerIrq,
  output logic [1:0]        dbg_state_o
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);

  state_e            state_q;
  logic [1:0]        wait_q;
  logic              ack_q;
  logic [DATA_W-1:0] din_q;
  logic [9:0]        led_q, sw_s1_q, sw_s2_q;
  logic [DATA_W-1:0] tcnt_q, presc_q;
  logic              irq_q;

  logic              accept, is_ram, ram_we, ram_re;
  logic              wr_led, wr_tcnt, wr_tstat, tick, expire;
  logic [DATA_W-1:0] rd_mux, ram_rdata;

  // Everything is decided at the IDLE acceptance edge; later bus changes are ignored.
  assign accept   = (state_q == ST_IDLE) && Req;
  assign is_ram   = ~ADDR[7];
  assign ram_we   = accept && W && is_ram;
  assign ram_re   = accept && !W && is_ram;
  assign wr_led   = accept && W && (ADDR[7:4] == ADDR_LEDR[7:4]);
  assign wr_tcnt  = accept && W && (ADDR[7:4] == ADDR_TCNT[7:4]);
  assign wr_tstat = accept && W && (ADDR[7:4] == ADDR_TSTAT[7:4]);

  always_comb begin
    rd_mux = '0;
    if (ADDR[7]) begin
      if (ADDR[7:4] == ADDR_LEDR[7:4])       rd_mux = DATA_W'(led_q);
      else if (ADDR[7:4] == ADDR_SW[7:4])    rd_mux = DATA_W'(sw_s2_q);
      else if (ADDR[7:4] == ADDR_TCNT[7:4])  rd_mux = tcnt_q;
      else if (ADDR[7:4] == ADDR_TSTAT[7:4]) rd_mux = DATA_W'(irq_q);
    end
  end

  bus_ram #(.DEPTH(RAM_DEPTH), .WIDTH(DATA_W)) u_ram (
    .clk_i   (Clock),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ADDR[RAM_AW-1:0]),
    .wdata_i (DOUT),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      din_q   <= '0;
      led_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Req) begin
            if (W) begin
              if (wr_led) led_q <= DOUT[9:0];
              ack_q   <= 1'b1;
              state_q <= ST_RESP;
            end else if (is_ram) begin
              wait_q  <= 2'(RAM_WAIT);
              state_q <= ST_RWAIT;
            end else begin
              din_q   <= rd_mux;
              ack_q   <= 1'b1;
              state_q <= ST_RESP;
            end
          end
        end
        ST_RWAIT: begin
          if (wait_q == 2'd0) begin
            din_q   <= ram_rdata;
            ack_q   <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        ST_RESP: begin
          if (!Req) begin
            ack_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // A bus load of the count beats a same-edge decrement; expiry beats a status clear.
  assign tick   = (presc_q == DATA_W'(TICK_DIV - 1));
  assign expire = !wr_tcnt && tick && (tcnt_q == DATA_W'(1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tcnt_q  <= '0;
      presc_q <= '0;
      irq_q   <= 1'b0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      if (wr_tcnt) begin
        tcnt_q  <= DOUT;
        presc_q <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + DATA_W'(1);
        if (tick && (tcnt_q != '0)) tcnt_q <= tcnt_q - DATA_W'(1);
      end
      if (expire)        irq_q <= 1'b1;
      else if (wr_tstat) irq_q <= 1'b0;
    end
  end

  assign DIN         = din_q;
  assign Ack         = ack_q;
  assign LEDR        = led_q;
  assign TimerIrq    = irq_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: bus transactions, peripherals, timer
// and reset behaviour, checked with immediate assertions against hand values.
module tb_mem_bus_responder;

  logic        Clock;
  logic        Resetn;
  logic        Req;
  logic [7:0]  ADDR;
  logic        W;
  logic [15:0] DOUT;
  logic [15:0] DIN;
  logic        Ack;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic        TimerIrq;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_responder #(
    .DATA_W(16), .ADDR_W(8), .RAM_DEPTH(128), .RAM_WAIT(1), .TICK_DIV(1)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Req         (Req),
    .ADDR        (ADDR),
    .W           (W),
    .DOUT        (DOUT),
    .DIN         (DIN),
    .Ack         (Ack),
    .SW          (SW),
    .LEDR        (LEDR),
    .TimerIrq    (TimerIrq),
    .dbg_state_o (dbg_state)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full 4-phase transaction; hold keeps Req high extra cycles after Ack.
  task automatic txn(input logic w, input logic [7:0] a, input logic [15:0] d,
                     input int hold, output logic [15:0] rd, output int lat);
    @(posedge Clock); #1;
    Req = 1'b1; W = w; ADDR = a; DOUT = d;
    lat = 0;
    while (1) begin
      @(posedge Clock); #1;
      lat++;
      if (Ack || lat >= 20) break;
    end
    check("txn_ack", 32'(Ack), 32'd1);
    rd = DIN;
    for (int i = 0; i < hold; i++) begin
      DOUT = d ^ 16'h03C3 ^ 16'(i);
      @(posedge Clock); #1;
      check("hold_ack", 32'(Ack), 32'd1);
      check("hold_din", 32'(DIN), 32'(rd));
    end
    Req = 1'b0;
    @(posedge Clock); #1;
    check("ack_drop", 32'(Ack), 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    int lat;

    Resetn = 1'b0; Req = 1'b0; ADDR = '0; W = 1'b0; DOUT = '0; SW = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_ledr", 32'(LEDR), 32'd0);
    check("rst_irq", 32'(TimerIrq), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    Resetn = 1'b1;

    txn(1'b0, 8'hA0, 16'h0000, 0, rd, lat);
    check("tcnt_rst_rd", 32'(rd), 32'd0);
    check("tcnt_rst_lat", 32'(lat), 32'd1);

    // RAM write then read with one wait cycle
    txn(1'b1, 8'h05, 16'h1234, 0, rd, lat);
    check("ram_wr_lat", 32'(lat), 32'd1);
    txn(1'b0, 8'h05, 16'h0000, 2, rd, lat);
    check("ram_rd_lat", 32'(lat), 32'd3);
    check("ram_rd_data", 32'(rd), 32'h1234);
    txn(1'b1, 8'h7F, 16'hBEEF, 0, rd, lat);
    txn(1'b0, 8'h7F, 16'h0000, 0, rd, lat);
    check("ram_top_data", 32'(rd), 32'hBEEF);

    // LED register and switch synchroniser
    txn(1'b1, 8'h80, 16'h03FF, 0, rd, lat);
    check("led_val", 32'(LEDR), 32'h03FF);
    txn(1'b0, 8'h80, 16'h0000, 0, rd, lat);
    check("led_rd", 32'(rd), 32'h03FF);
    check("led_rd_lat", 32'(lat), 32'd1);
    SW = 10'h155;
    repeat (2) @(posedge Clock);
    txn(1'b0, 8'h90, 16'h0000, 0, rd, lat);
    check("sw_rd", 32'(rd), 32'h0155);

    // Timer: load 3, observe countdown and sticky expiry
    @(posedge Clock); #1;
    Req = 1'b1; W = 1'b1; ADDR = 8'hA0; DOUT = 16'd3;
    @(posedge Clock); #1;
    check("tmr_load", 32'(dut.tcnt_q), 32'd3);
    check("tmr_ack", 32'(Ack), 32'd1);
    Req = 1'b0;
    @(posedge Clock); #1;
    check("tmr_c2", 32'(dut.tcnt_q), 32'd2);
    @(posedge Clock); #1;
    check("tmr_c1", 32'(dut.tcnt_q), 32'd1);
    check("tmr_irq_pre", 32'(TimerIrq), 32'd0);
    @(posedge Clock); #1;
    check("tmr_c0", 32'(dut.tcnt_q), 32'd0);
    check("tmr_irq_set", 32'(TimerIrq), 32'd1);
    @(posedge Clock); #1;
    check("tmr_no_wrap", 32'(dut.tcnt_q), 32'd0);
    check("tmr_irq_stick", 32'(TimerIrq), 32'd1);
    txn(1'b0, 8'hB0, 16'h0000, 0, rd, lat);
    check("tstat_rd", 32'(rd), 32'd1);
    txn(1'b1, 8'hB0, 16'h0000, 0, rd, lat);
    check("tstat_clr", 32'(TimerIrq), 32'd0);
    txn(1'b1, 8'hA0, 16'h0000, 0, rd, lat);
    repeat (3) @(posedge Clock);
    #1;
    check("tmr_zero_irq", 32'(TimerIrq), 32'd0);
    txn(1'b0, 8'hA0, 16'h0000, 0, rd, lat);
    check("tmr_zero_rd", 32'(rd), 32'd0);

    // Req held high after Ack with DOUT changing: single commit
    txn(1'b1, 8'h80, 16'h00AA, 5, rd, lat);
    check("once_led", 32'(LEDR), 32'h00AA);
    check("once_lat", 32'(lat), 32'd1);

    // Reset during RWAIT
    @(posedge Clock); #1;
    Req = 1'b1; W = 1'b0; ADDR = 8'h05;
    @(posedge Clock); #1;
    check("rwait_state", 32'(dbg_state), 32'd1);
    Resetn = 1'b0;
    #1;
    check("rwait_rst_state", 32'(dbg_state), 32'd0);
    check("rwait_rst_ack", 32'(Ack), 32'd0);
    check("rwait_rst_led", 32'(LEDR), 32'd0);
    Req = 1'b0;
    @(posedge Clock); #1;
    Resetn = 1'b1;

    // Reset during RESP drops Ack immediately
    @(posedge Clock); #1;
    Req = 1'b1; W = 1'b0; ADDR = 8'h90;
    @(posedge Clock); #1;
    check("resp_ack", 32'(Ack), 32'd1);
    Resetn = 1'b0;
    #1;
    check("resp_rst_ack", 32'(Ack), 32'd0);
    check("resp_rst_din", 32'(DIN), 32'd0);
    Req = 1'b0;
    @(posedge Clock); #1;
    Resetn = 1'b1;

    // RAM survives reset; unmapped addresses read 0 and ignore writes
    txn(1'b0, 8'h05, 16'h0000, 0, rd, lat);
    check("ram_keep", 32'(rd), 32'h1234);
    txn(1'b1, 8'hF0, 16'hFFFF, 0, rd, lat);
    check("unmap_wr_lat", 32'(lat), 32'd1);
    txn(1'b0, 8'hF0, 16'h0000, 0, rd, lat);
    check("unmap_rd", 32'(rd), 32'd0);
    check("unmap_lat", 32'(lat), 32'd1);
    check("unmap_led", 32'(LEDR), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
